if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the basic pipelined RV32 processor. It owns the program counter, issues one instruction-memory request at a time, and drives the IF/ID pipeline register consumed by the decode stage, where the register file is read. It honours stall and flush from the hazard logic and redirects on taken branches. In-flight fetches are never lost and never duplicated.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: instruction placed in IF/ID when it is empty (addi x0,x0,0).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  fetch request outstanding.
- imem_addr  out  32  fetch address; equals current PC; stable while imem_req=1 until completion.
- imem_valid  in  1  response for the outstanding request, sampled at the edge; may be high in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_valid=1.
- stall  in  1  hold IF/ID and PC.
- flush  in  1  squash IF/ID contents.
- branch_taken  in  1  single-cycle redirect pulse.
- branch_target  in  32  redirect address; bits [1:0] are forced to 0.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_pc4  out  32  if_id_pc + 4, mod 2^32.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

## Operation
- States:
  - FETCH: imem_req=1.
  - HOLD: a response is buffered because of stall; imem_req=0.
  - DRAIN: waiting to discard a stale response after a redirect; imem_req=0.
- FETCH, imem_valid=1, no stall, no redirect:
  - IF/ID ← {pc, pc+4, imem_rdata}; valid ← 1.
  - pc ← pc+4; remain in FETCH.
- FETCH, imem_valid=1, stall=1: capture {pc, imem_rdata} in a 1-entry buffer; pc ← pc+4; go to HOLD.
- HOLD, stall=0: IF/ID ← buffer; valid ← 1; go to FETCH.
- Stall=1 with no completion: IF/ID and pc unchanged.
- Flush: at the edge, if_id_valid ← 0 and if_id_instr ← NOP_INSTR. Flush overrides stall.
  - Flush in HOLD also discards the buffer and returns to FETCH; pc is not rewound.
- Redirect (branch_taken) behaves as a flush of IF/ID plus pc ← {branch_target[31:2], 2'b00}. It overrides stall and the buffer.
  - If FETCH and imem_valid=0 at that edge (request outstanding): go to DRAIN.
  - If imem_valid=1 at that edge: the response is discarded; stay in FETCH at the target.
- DRAIN, imem_valid=1: discard the data; go to FETCH.
- imem_valid while imem_req=0 and not in DRAIN is ignored.
- PC arithmetic is 32-bit; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - pc=RESET_PC; state=FETCH; imem_req=0 while reset is asserted.
  - if_id_pc=0, if_id_pc4=4, if_id_instr=NOP_INSTR, if_id_valid=0.
- imem_req and imem_addr are decoded from the state and pc registers (no combinational path from stall or flush). imem_req rises in the first cycle after reset deasserts.
- All if_id_* outputs are registered.
- Latency: a response accepted at edge N is visible on if_id_* after edge N.
- With a zero-wait memory (imem_valid tied high), throughput is 1 instruction per cycle.
- HOLD to IF/ID adds one cycle after stall falls; FETCH resumes in that same cycle.
- DRAIN lasts until the stale response arrives, then the target is issued the next cycle.
- Reset during DRAIN or HOLD aborts immediately; the memory is reset by the same reset.

## Test plan
- Zero-wait memory, RESET_PC=0, stream words 0x11,0x22,0x33 → if_id_pc 0,4,8 on consecutive cycles; if_id_pc4 4,8,12; valid=1 from the first fetch.
- Stall held 3 cycles while the response for pc=8 arrives → IF/ID frozen at pc=4; imem_req=0; after stall drops, if_id_pc=8 with the correct word; no address repeated or skipped.
- 2-cycle memory, branch_taken to 0x100 while the request for 0x10 is outstanding → DRAIN; the stale word is never visible; next imem_addr=0x100; if_id_valid=0 in between.
- branch_target=0x203 with stall=1 → pc=0x200; IF/ID squashed to NOP, valid=0.
- Flush and stall together with IF/ID holding pc=0x40 → if_id_valid=0, if_id_instr=0x00000013.
- RESET_PC=32'hFFFF_FFFC, zero-wait memory → first if_id_pc4=0, second if_id_pc=0; reset asserted mid-fetch → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request
// in flight at a time and drives the IF/ID register read by decode. A stalled
// response is parked in a one-entry buffer, and a response that is still in
// flight when a redirect happens is drained and dropped, so no fetched word is
// lost or delivered twice.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Fetch-side state (stage 0)
    state_t      state_p0;
    state_t      state_nx;
    logic [31:0] pc_p0;
    logic [31:0] pc_nx;
    logic [31:0] buf_pc_p0;
    logic [31:0] buf_instr_p0;

    // IF/ID register (stage 1)
    logic [31:0] if_id_pc_p1;
    logic [31:0] if_id_pc4_p1;
    logic [31:0] if_id_instr_p1;
    logic        if_id_vld_p1;

    // Per-edge decisions from the FSM
    logic cap_buf;
    logic ld_mem;
    logic ld_buf;
    logic squash;

    // Sequential PC increment; 32-bit wrap is intended.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // The request is a pure decode of the state register; reset gates it so
    // nothing is requested while reset is held.
    assign imem_req  = (state_p0 == S_FETCH) && !reset;
    assign imem_addr = pc_p0;

    assign if_id_pc    = if_id_pc_p1;
    assign if_id_pc4   = if_id_pc4_p1;
    assign if_id_instr = if_id_instr_p1;
    assign if_id_valid = if_id_vld_p1;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= S_FETCH;
        end else begin
            state_p0 <= state_nx;
        end
    end

    // Next-state, next-PC and IF/ID load decisions
    always_comb begin
        state_nx = state_p0;
        pc_nx    = pc_p0;
        cap_buf  = 1'b0;
        ld_mem   = 1'b0;
        ld_buf   = 1'b0;
        squash   = 1'b0;
        if (branch_taken) begin
            // Redirect wins over stall, flush and the buffer. A request still
            // in flight must have its response swallowed before refetching.
            squash = 1'b1;
            pc_nx  = align_pc(branch_target);
            if ((state_p0 != S_HOLD) && !imem_valid) begin
                state_nx = S_DRAIN;
            end else begin
                state_nx = S_FETCH;
            end
        end else begin
            case (state_p0)
                S_FETCH: begin
                    if (imem_valid) begin
                        pc_nx = pc_inc(pc_p0);
                        if (flush) begin
                            squash = 1'b1;
                        end else if (stall) begin
                            cap_buf  = 1'b1;
                            state_nx = S_HOLD;
                        end else begin
                            ld_mem = 1'b1;
                        end
                    end else if (flush) begin
                        squash = 1'b1;
                    end
                end
                S_HOLD: begin
                    // PC already points past the buffered word, so a flush
                    // simply drops the buffer without rewinding.
                    if (flush) begin
                        squash   = 1'b1;
                        state_nx = S_FETCH;
                    end else if (!stall) begin
                        ld_buf   = 1'b1;
                        state_nx = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (flush) begin
                        squash = 1'b1;
                    end
                    if (imem_valid) begin
                        state_nx = S_FETCH;
                    end
                end
                default: begin
                    state_nx = S_FETCH;
                end
            endcase
        end
    end

    // PC, stall buffer and IF/ID register updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0          <= RESET_PC;
            buf_pc_p0      <= 32'd0;
            buf_instr_p0   <= 32'd0;
            if_id_pc_p1    <= 32'd0;
            if_id_pc4_p1   <= 32'd4;
            if_id_instr_p1 <= NOP_INSTR;
            if_id_vld_p1   <= 1'b0;
        end else begin
            pc_p0 <= pc_nx;
            if (cap_buf) begin
                buf_pc_p0    <= pc_p0;
                buf_instr_p0 <= imem_rdata;
            end
            if (squash) begin
                if_id_instr_p1 <= NOP_INSTR;
                if_id_vld_p1   <= 1'b0;
            end else if (ld_mem) begin
                if_id_pc_p1    <= pc_p0;
                if_id_pc4_p1   <= pc_inc(pc_p0);
                if_id_instr_p1 <= imem_rdata;
                if_id_vld_p1   <= 1'b1;
            end else if (ld_buf) begin
                if_id_pc_p1    <= buf_pc_p0;
                if_id_pc4_p1   <= pc_inc(buf_pc_p0);
                if_id_instr_p1 <= buf_instr_p0;
                if_id_vld_p1   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with a scoreboard of expected IF/ID
// entries checked by an independent monitor, plus direct control checks.
module tb_if_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;

    logic        zw = 1'b1;       // 1: zero-wait memory, 0: 2-cycle memory
    logic        mem_busy;
    logic [31:0] mem_addr;

    logic        imem_req, imem_valid, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_pc4, if_id_instr;

    logic        imem_req_w, if_id_valid_w;
    logic [31:0] imem_addr_w, imem_rdata_w, if_id_pc_w, if_id_pc4_w, if_id_instr_w;

    // Memory contents: word at address a is 0x11 * (a/4 + 1)
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h11 * ((a >> 2) + 32'd1);
    endfunction

    assign imem_valid   = zw ? 1'b1 : mem_busy;
    assign imem_rdata   = zw ? word(imem_addr) : word(mem_addr);
    assign imem_rdata_w = word(imem_addr_w);

    // 2-cycle memory: accepts in the request cycle, answers the next cycle
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_busy <= 1'b0;
            mem_addr <= 32'd0;
        end else if (!zw) begin
            if (mem_busy) begin
                mem_busy <= 1'b0;
            end else if (imem_req) begin
                mem_busy <= 1'b1;
                mem_addr <= imem_addr;
            end
        end
    end

    if_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_valid(1'b1), .imem_rdata(imem_rdata_w),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_pc(if_id_pc_w), .if_id_pc4(if_id_pc4_w),
        .if_id_instr(if_id_instr_w), .if_id_valid(if_id_valid_w)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc;
        e.pc4 = pc + 32'd4;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Monitor: each newly presented valid IF/ID entry is popped and compared
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_instr = 32'd0;
    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (if_id_valid && (!prev_v || if_id_pc !== prev_pc || if_id_instr !== prev_instr)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ifid_unexpected: got pc %h instr %h expected no entry", if_id_pc, if_id_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ifid_pc", if_id_pc, mon_e.pc);
                    check("ifid_pc4", if_id_pc4, mon_e.pc4);
                    check("ifid_instr", if_id_instr, mon_e.instr);
                end
            end
            prev_v = if_id_valid;
            prev_pc = if_id_pc;
            prev_instr = if_id_instr;
        end
    end

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_if_id_pc", if_id_pc, 32'd0);
        check("rst_if_id_pc4", if_id_pc4, 32'd4);
        check("rst_if_id_instr", if_id_instr, 32'h13);
        check("rst_if_id_valid", if_id_valid, 0);
        check("rst_imem_req", imem_req, 0);

        // Zero-wait stream, then a 3-cycle stall as pc=8 completes
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("s1_req_after_reset", imem_req, 1);
        check("s1_first_addr", imem_addr, 32'd0);
        push(32'd0, 32'h11);
        push(32'd4, 32'h22);
        push(32'd8, 32'h33);
        push(32'd12, 32'h44);
        repeat (2) @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        check("s2_hold_req", imem_req, 0);
        check("s2_frozen_pc", if_id_pc, 32'd4);
        @(negedge clk);
        check("s2_frozen_pc_b", if_id_pc, 32'd4);
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        check("s2_resume_req", imem_req, 1);
        check("s2_resume_addr", imem_addr, 32'd12);
        @(negedge clk);
        check_drained("s2_left");
        reset = 1'b1;

        // 2-cycle memory, redirect to 0x100 while 0x10 is outstanding
        zw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("s3_first_req", imem_req, 1);
        push(32'd0, 32'h11);
        push(32'd4, 32'h22);
        push(32'd8, 32'h33);
        push(32'hC, 32'h44);
        push(32'h100, 32'h451);
        repeat (8) @(negedge clk);
        check("s3_addr_0x10", imem_addr, 32'h10);
        branch_taken = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        branch_taken = 1'b0;
        check("s3_drain_req", imem_req, 0);
        check("s3_drain_valid", if_id_valid, 0);
        @(negedge clk);
        check("s3_target_addr", imem_addr, 32'h100);
        check("s3_target_req", imem_req, 1);
        check("s3_gap_valid", if_id_valid, 0);
        repeat (3) @(negedge clk);
        check_drained("s3_left");
        reset = 1'b1;

        // Misaligned redirect under stall
        zw = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push(32'd0, 32'h11);
        push(32'd4, 32'h22);
        push(32'h200, 32'h891);
        repeat (2) @(negedge clk);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h203;
        @(negedge clk);
        stall = 1'b0;
        branch_taken = 1'b0;
        check("s4_aligned_addr", imem_addr, 32'h200);
        check("s4_squash_valid", if_id_valid, 0);
        check("s4_squash_instr", if_id_instr, 32'h13);
        @(negedge clk);
        check_drained("s4_left");
        reset = 1'b1;

        // Flush together with stall while IF/ID holds pc=0x40
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(32'(i * 4), 32'(32'h11 * (i + 1)));
        end
        repeat (17) @(negedge clk);
        check("s5_holds_0x40", if_id_pc, 32'h40);
        stall = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        check("s5_flush_valid", if_id_valid, 0);
        check("s5_flush_instr", if_id_instr, 32'h13);
        check_drained("s5_left");
        reset = 1'b1;

        // PC wrap from 0xFFFFFFFC, then asynchronous reset mid-fetch
        @(negedge clk);
        reset = 1'b0;
        push(32'd0, 32'h11);
        push(32'd4, 32'h22);
        #1;
        check("s6_w_addr", imem_addr_w, 32'hFFFF_FFFC);
        check("s6_w_req", imem_req_w, 1);
        @(negedge clk);
        check("s6_w_pc1", if_id_pc_w, 32'hFFFF_FFFC);
        check("s6_w_pc4_1", if_id_pc4_w, 32'd0);
        check("s6_w_instr1", if_id_instr_w, 32'h4000_0000);
        check("s6_w_valid1", if_id_valid_w, 1);
        @(negedge clk);
        check("s6_w_pc2", if_id_pc_w, 32'd0);
        check("s6_w_pc4_2", if_id_pc4_w, 32'd4);
        check("s6_w_instr2", if_id_instr_w, 32'h11);
        #2;
        reset = 1'b1;
        #1;
        check("s6_ar_pc", if_id_pc_w, 32'd0);
        check("s6_ar_pc4", if_id_pc4_w, 32'd4);
        check("s6_ar_instr", if_id_instr_w, 32'h13);
        check("s6_ar_valid", if_id_valid_w, 0);
        check("s6_ar_req", imem_req_w, 0);
        check("s6_ar_main_valid", if_id_valid, 0);
        check_drained("s6_left");

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
